// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : divider_pkg
// Brief    : Shared helpers and per-stage sideband type for divider_pipe_sd.
// Revision : 1.0  initial release
// ============================================================================
package divider_pkg;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int num_stages(input int n, input int bps);
        return ceil_div(n, bps);
    endfunction

    // The final stage retires whatever bits remain after the full-width stages.
    function automatic int last_steps(input int n, input int bps);
        return n - (ceil_div(n, bps) - 1) * bps;
    endfunction

    // The tag rides in a parallel vector because its width is a module parameter.
    typedef struct packed {
        logic valid;
        logic q_neg;
        logic r_neg;
        logic div0;
        logic ovf;
    } side_t;

endpackage
`default_nettype wire

// File: rtl/divider_sd_stage.sv
`default_nettype none
// ============================================================================
// Module   : divider_sd_stage
// Brief    : One register stage of the restoring divider, retiring STEPS
//            quotient bits MSB first.
// Revision : 1.0  initial release
// ============================================================================
module divider_sd_stage
    import divider_pkg::*;
#(
    parameter int N     = 21,
    parameter int M     = 13,
    parameter int STEPS = 1,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic [M-1:0]     rem_in,
    input  logic [N-1:0]     dq_in,
    input  logic [M-1:0]     dvs_in,
    input  side_t            side_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic [M-1:0]     rem_out,
    output logic [N-1:0]     dq_out,
    output logic [M-1:0]     dvs_out,
    output side_t            side_out,
    output logic [TAG_W-1:0] tag_out
);

    // dq holds unconsumed dividend bits at the top and quotient bits at the bottom.
    logic [M-1:0] w_rem;
    logic [N-1:0] w_dq;
    logic [M:0]   w_part;

    always_comb begin
        w_rem  = rem_in;
        w_dq   = dq_in;
        w_part = '0;
        for (int i = 0; i < STEPS; i++) begin
            w_part = {w_rem, w_dq[N-1]};
            if (w_part >= {1'b0, dvs_in}) begin
                w_part = w_part - {1'b0, dvs_in};
                w_dq   = {w_dq[N-2:0], 1'b1};
            end else begin
                w_dq   = {w_dq[N-2:0], 1'b0};
            end
            w_rem = w_part[M-1:0];
        end
    end

    logic [M-1:0]     r_rem;
    logic [N-1:0]     r_dq;
    logic [M-1:0]     r_dvs;
    side_t            r_side;
    logic [TAG_W-1:0] r_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_side <= '0;
        end else if (advance) begin
            r_rem  <= w_rem;
            r_dq   <= w_dq;
            r_dvs  <= dvs_in;
            r_side <= side_in;
            r_tag  <= tag_in;
        end
    end

    assign rem_out  = r_rem;
    assign dq_out   = r_dq;
    assign dvs_out  = r_dvs;
    assign side_out = r_side;
    assign tag_out  = r_tag;

endmodule
`default_nettype wire

// File: rtl/divider_pipe_sd.sv
`default_nettype none
// ============================================================================
// Module   : divider_pipe_sd
// Brief    : Pipelined signed/unsigned restoring divider with valid/ready
//            backpressure, tag passthrough and div0/overflow flags.
// Revision : 1.0  initial release
// ============================================================================
module divider_pipe_sd
    import divider_pkg::*;
#(
    parameter int N     = 21,
    parameter int M     = 13,
    parameter int BPS   = 1,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [N-1:0]     in_dividend,
    input  logic [M-1:0]     in_divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_quotient,
    output logic [M-1:0]     out_remainder,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_div0,
    output logic             out_ovf
);

    localparam int NSTG       = num_stages(N, BPS);
    localparam int LAST_STEPS = last_steps(N, BPS);
    localparam logic [N-1:0] C_DVD_MIN = {1'b1, {(N-1){1'b0}}};

    logic w_advance;
    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;

    // Most-negative operands negate to themselves, which reads correctly as an unsigned magnitude.
    logic [N-1:0] w_dvd_mag;
    logic [M-1:0] w_dvs_mag;
    assign w_dvd_mag = (in_signed && in_dividend[N-1]) ? -in_dividend : in_dividend;
    assign w_dvs_mag = (in_signed && in_divisor[M-1])  ? -in_divisor  : in_divisor;

    logic [N-1:0]     r0_dq;
    logic [M-1:0]     r0_dvs;
    side_t            r0_side;
    logic [TAG_W-1:0] r0_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            r0_side <= '0;
        end else if (w_advance) begin
            r0_side.valid <= in_valid;
            r0_side.q_neg <= in_signed & (in_dividend[N-1] ^ in_divisor[M-1]);
            r0_side.r_neg <= in_signed & in_dividend[N-1];
            r0_side.div0  <= (in_divisor == '0);
            r0_side.ovf   <= in_signed & (in_dividend == C_DVD_MIN) & (&in_divisor);
            r0_dq         <= w_dvd_mag;
            r0_dvs        <= w_dvs_mag;
            r0_tag        <= in_tag;
        end
    end

    logic [M-1:0]     w_rem  [0:NSTG];
    logic [N-1:0]     w_dq   [0:NSTG];
    logic [M-1:0]     w_dvs  [0:NSTG];
    side_t            w_side [0:NSTG];
    logic [TAG_W-1:0] w_tag  [0:NSTG];

    assign w_rem[0]  = '0;
    assign w_dq[0]   = r0_dq;
    assign w_dvs[0]  = r0_dvs;
    assign w_side[0] = r0_side;
    assign w_tag[0]  = r0_tag;

    generate
        for (genvar g = 1; g <= NSTG; g++) begin : g_stage
            localparam int STEPS = (g == NSTG) ? LAST_STEPS : BPS;
            divider_sd_stage #(
                .N     (N),
                .M     (M),
                .STEPS (STEPS),
                .TAG_W (TAG_W)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .advance  (w_advance),
                .rem_in   (w_rem[g-1]),
                .dq_in    (w_dq[g-1]),
                .dvs_in   (w_dvs[g-1]),
                .side_in  (w_side[g-1]),
                .tag_in   (w_tag[g-1]),
                .rem_out  (w_rem[g]),
                .dq_out   (w_dq[g]),
                .dvs_out  (w_dvs[g]),
                .side_out (w_side[g]),
                .tag_out  (w_tag[g])
            );
        end
    endgenerate

    assign out_valid = w_side[NSTG].valid;

    always_comb begin
        out_quotient  = '0;
        out_remainder = '0;
        out_tag       = '0;
        out_div0      = 1'b0;
        out_ovf       = 1'b0;
        if (w_side[NSTG].valid) begin
            out_tag = w_tag[NSTG];
            if (w_side[NSTG].div0) begin
                out_quotient = '1;
                out_div0     = 1'b1;
            end else if (w_side[NSTG].ovf) begin
                out_quotient = C_DVD_MIN;
                out_ovf      = 1'b1;
            end else begin
                out_quotient  = w_side[NSTG].q_neg ? -w_dq[NSTG]  : w_dq[NSTG];
                out_remainder = w_side[NSTG].r_neg ? -w_rem[NSTG] : w_rem[NSTG];
            end
        end
    end

endmodule
`default_nettype wire
